// File: rtl/mixpix_readout_seq.sv
// mixpix_readout_seq: readout sequencer for the MixPix pixel array.
// For each pixel set in the frame mask, in ascending index order, it runs
// GAP -> RST -> INTEG -> SAMPLE -> CMP -> CAP. It drives the photodiode
// select/shunt pairs and the analog strobes, and it returns one resynchronised
// comparator bit per pixel.
// Optional build macro MIXPIX_RESULT_REG_EN adds the o_res_word result vector.
// Parameter ranges: N_PIX 2..64, RST_CYC >= 1, SH_CYC >= 1, CMP_CYC >= 2.
// Each phase counter load (RST_CYC-1, SH_CYC-1, CMP_CYC-1) must fit in the
// counter width chosen below.
`timescale 1ns/1ps

module mixpix_readout_seq #(
  parameter int N_PIX   = 12,
  parameter int INT_W   = 8,
  parameter int RST_CYC = 4,
  parameter int SH_CYC  = 2,
  parameter int CMP_CYC = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_cont,
  input  logic [INT_W-1:0] i_int_time,
  input  logic [N_PIX-1:0] i_pix_mask,
  input  logic             i_cmp_in,
  output logic [N_PIX-1:0] o_pd_a,
  output logic [N_PIX-1:0] o_pd_b,
  output logic             o_sw1,
  output logic             o_sw2,
  output logic             o_sh_rst,
  output logic             o_sh,
  output logic             o_sh_cmp,
  output logic             o_busy,
  output logic             o_res_valid,
  output logic [5:0]       o_res_pix,
  output logic             o_res_bit,
  output logic             o_frame_done
`ifdef MIXPIX_RESULT_REG_EN
  ,
  output logic [N_PIX-1:0] o_res_word
`endif
);

  // Phase down-counter width. It is wide enough for the integration time
  // and for fixed phase lengths of up to 256 cycles.
  localparam int CNT_W = (INT_W > 8) ? INT_W : 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_RST,
    S_INTEG,
    S_SAMPLE,
    S_CMP,
    S_CAP
  } state_t;

  // Lowest set bit of mask whose index is >= from; MSB of the result = found
  function automatic logic [6:0] f_find(input logic [N_PIX-1:0] mask, input int from);
    logic [6:0] res;
    res = '0;
    for (int i = N_PIX - 1; i >= 0; i--) begin
      if (mask[i] && (i >= from)) res = {1'b1, 6'(i)};
    end
    return res;
  endfunction

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [5:0]       r_pix;
  logic [N_PIX-1:0] r_mask;
  logic [INT_W-1:0] r_int;
  logic             r_busy;
  logic             r_sync1;
  logic             r_cmp_s;
  logic [N_PIX-1:0] r_pd_a;
  logic [N_PIX-1:0] r_pd_b;
  logic             r_sw1;
  logic             r_sw2;
  logic             r_sh_rst;
  logic             r_sh;
  logic             r_sh_cmp;
  logic             r_res_valid;
  logic [5:0]       r_res_pix;
  logic             r_res_bit;
  logic             r_frame_done;

  state_t           w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [5:0]       w_pix_next;
  logic             w_latch;
  logic             w_res_fire;
  logic             w_done_next;
  logic             w_busy_next;
  logic [6:0]       w_first;
  logic [6:0]       w_succ;
  logic [CNT_W-1:0] w_int_load;
  logic [N_PIX-1:0] w_pix_onehot;
  logic             w_bus_on;
  logic             w_shunt_off;

  // First pixel of a new frame comes from the live mask, because it is latched
  // at the same edge. The successor pixel comes from the latched mask.
  assign w_first    = f_find(i_pix_mask, 0);
  assign w_succ     = f_find(r_mask, int'(r_pix) + 1);
  // An integration time of 0 behaves as 1 cycle, so the counter load is T-1.
  assign w_int_load = (r_int == '0) ? '0 : (CNT_W'(r_int) - CNT_W'(1));

  // One-hot decode of the pixel that the next state will address
  genvar gi;
  generate
    for (gi = 0; gi < N_PIX; gi++) begin : g_onehot
      assign w_pix_onehot[gi] = (w_pix_next == 6'(gi));
    end
  endgenerate

  assign w_bus_on    = (w_state_next == S_RST) || (w_state_next == S_INTEG) ||
                       (w_state_next == S_SAMPLE);
  assign w_shunt_off = w_bus_on || (w_state_next == S_GAP) || (w_state_next == S_CMP);

  // Next-state, counter, pixel and event decode; abort overrides everything
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_pix_next   = r_pix;
    w_latch      = 1'b0;
    w_res_fire   = 1'b0;
    w_done_next  = 1'b0;
    w_busy_next  = r_busy;
    if (i_abort) begin
      w_state_next = S_IDLE;
      w_cnt_next   = '0;
      w_busy_next  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // r_busy is still high here for one cycle after the final CAP,
          // so a start that arrives during frame_done is ignored.
          w_busy_next = 1'b0;
          if (i_start && !r_busy) begin
            w_latch = 1'b1;
            if (w_first[6]) begin
              w_state_next = S_GAP;
              w_pix_next   = w_first[5:0];
              w_busy_next  = 1'b1;
            end else begin
              w_done_next = 1'b1;
            end
          end
        end
        S_GAP: begin
          w_state_next = S_RST;
          w_cnt_next   = CNT_W'(RST_CYC - 1);
        end
        S_RST: begin
          if (r_cnt == '0) begin
            w_state_next = S_INTEG;
            w_cnt_next   = w_int_load;
          end else begin
            w_cnt_next = r_cnt - CNT_W'(1);
          end
        end
        S_INTEG: begin
          if (r_cnt == '0) begin
            w_state_next = S_SAMPLE;
            w_cnt_next   = CNT_W'(SH_CYC - 1);
          end else begin
            w_cnt_next = r_cnt - CNT_W'(1);
          end
        end
        S_SAMPLE: begin
          if (r_cnt == '0) begin
            w_state_next = S_CMP;
            w_cnt_next   = CNT_W'(CMP_CYC - 1);
          end else begin
            w_cnt_next = r_cnt - CNT_W'(1);
          end
        end
        S_CMP: begin
          if (r_cnt == '0) begin
            w_state_next = S_CAP;
          end else begin
            w_cnt_next = r_cnt - CNT_W'(1);
          end
        end
        S_CAP: begin
          w_res_fire = 1'b1;
          if (w_succ[6]) begin
            w_state_next = S_GAP;
            w_pix_next   = w_succ[5:0];
          end else begin
            w_done_next = 1'b1;
            if (i_cont && w_first[6]) begin
              // Back-to-back frame: relatch inputs, with no idle cycle
              w_latch      = 1'b1;
              w_state_next = S_GAP;
              w_pix_next   = w_first[5:0];
            end else begin
              // busy stays high during the frame_done cycle, then drops in IDLE
              w_state_next = S_IDLE;
            end
          end
        end
        default: begin
          w_state_next = S_IDLE;
          w_busy_next  = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state and all strobes registered from the decoded next state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_pix        <= '0;
      r_mask       <= '0;
      r_int        <= '0;
      r_busy       <= 1'b0;
      r_pd_a       <= '0;
      r_pd_b       <= '1;
      r_sw1        <= 1'b0;
      r_sw2        <= 1'b0;
      r_sh_rst     <= 1'b0;
      r_sh         <= 1'b0;
      r_sh_cmp     <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_pix    <= '0;
      r_res_bit    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_pix        <= w_pix_next;
      r_busy       <= w_busy_next;
      if (w_latch) begin
        r_mask <= i_pix_mask;
        r_int  <= i_int_time;
      end
      r_pd_a       <= w_bus_on ? w_pix_onehot : '0;
      r_pd_b       <= w_shunt_off ? ~w_pix_onehot : '1;
      r_sh_rst     <= (w_state_next == S_RST);
      r_sw1        <= (w_state_next == S_INTEG);
      r_sh         <= (w_state_next == S_SAMPLE);
      r_sh_cmp     <= (w_state_next == S_CMP);
      r_sw2        <= (w_state_next == S_CMP);
      r_res_valid  <= w_res_fire;
      r_frame_done <= w_done_next;
      if (w_res_fire) begin
        r_res_pix <= r_pix;
        r_res_bit <= r_cmp_s;
      end
    end
  end

  // Two-flop synchroniser for the asynchronous comparator output
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_cmp_s <= 1'b0;
    end else begin
      r_sync1 <= i_cmp_in;
      r_cmp_s <= r_sync1;
    end
  end

`ifdef MIXPIX_RESULT_REG_EN
  logic [N_PIX-1:0] r_res_word;
  logic             w_word_clr;

  // Clear on an explicit start. In continuous mode, clear at the end of the
  // first GAP, so the completed frame stays readable during frame_done.
  assign w_word_clr = (r_state == S_IDLE && w_latch) ||
                      (r_state == S_GAP && r_frame_done);

  generate
    for (gi = 0; gi < N_PIX; gi++) begin : g_res_word
      // Bit gi captures the result of pixel gi at the same edge as res_valid
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_res_word[gi] <= 1'b0;
        end else if (w_word_clr) begin
          r_res_word[gi] <= 1'b0;
        end else if (w_res_fire && (r_pix == 6'(gi))) begin
          r_res_word[gi] <= r_cmp_s;
        end
      end
    end
  endgenerate

  assign o_res_word = r_res_word;
`endif

  assign o_pd_a       = r_pd_a;
  assign o_pd_b       = r_pd_b;
  assign o_sw1        = r_sw1;
  assign o_sw2        = r_sw2;
  assign o_sh_rst     = r_sh_rst;
  assign o_sh         = r_sh;
  assign o_sh_cmp     = r_sh_cmp;
  assign o_busy       = r_busy;
  assign o_res_valid  = r_res_valid;
  assign o_res_pix    = r_res_pix;
  assign o_res_bit    = r_res_bit;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_mixpix_readout_seq.sv
// Directed testbench for mixpix_readout_seq with hand-computed expected timing.
// Cycle k = 1 is the first cycle after the edge that samples start.
// With default parameters, a pixel occupies cycles k..k+9+T and its result
// appears at k+10+T.
`timescale 1ns/1ps

module tb_mixpix_readout_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        cont = 1'b0;
  logic [7:0]  int_time = '0;
  logic [11:0] pix_mask = '0;
  logic        cmp_in = 1'b0;
  logic [11:0] pd_a, pd_b;
  logic        sw1, sw2, sh_rst, sh, sh_cmp, busy, res_valid, res_bit, frame_done;
  logic [5:0]  res_pix;
`ifdef MIXPIX_RESULT_REG_EN
  logic [11:0] res_word;
`endif

  mixpix_readout_seq dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort), .i_cont(cont),
    .i_int_time(int_time), .i_pix_mask(pix_mask), .i_cmp_in(cmp_in),
    .o_pd_a(pd_a), .o_pd_b(pd_b), .o_sw1(sw1), .o_sw2(sw2), .o_sh_rst(sh_rst),
    .o_sh(sh), .o_sh_cmp(sh_cmp), .o_busy(busy), .o_res_valid(res_valid),
    .o_res_pix(res_pix), .o_res_bit(res_bit), .o_frame_done(frame_done)
`ifdef MIXPIX_RESULT_REG_EN
    , .o_res_word(res_word)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_viol = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Invariant monitor: at most one pd_a bit, and never pd_a & pd_b on one pixel
  always @(negedge clk) begin
    if (rst_n) begin
      if ($countones(pd_a) > 1) n_viol++;
      if ((pd_a & pd_b) != 12'h000) n_viol++;
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n_shrst, n_sw1, n_sh, n_shcmp, n_sw2, n_rv, n_fd, n_busy, rv_cyc, fd_cyc;
    int ev_pix[3];
    int ev_cyc[3];
    int fd_list[3];
    logic [5:0] rv_pix;
    logic rv_bit;
    logic dropped;

    // ---------------- reset ----------------
    repeat (3) tick();
    check("rst_pd_b_asserted", {20'd0, pd_b}, 32'hFFF);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("rst_pd_b", {20'd0, pd_b}, 32'hFFF);
      check("rst_outs", {5'd0, pd_a, sw1, sw2, sh_rst, sh, sh_cmp, busy, res_valid,
                          frame_done, res_bit, res_pix}, 32'h0);
    end
    $display("reset: idle outputs observed for 20 cycles");

    // ---------------- single pixel ----------------
    pix_mask = 12'h004; int_time = 8'd3; cmp_in = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    n_shrst = 0; n_sw1 = 0; n_sh = 0; n_shcmp = 0; n_sw2 = 0; n_rv = 0;
    rv_cyc = 0; fd_cyc = 0; rv_pix = '0; rv_bit = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 1) begin
        check("sp_busy_rise", {31'd0, busy}, 32'd1);
        check("sp_gap_pd_a", {20'd0, pd_a}, 32'h000);
        check("sp_gap_pd_b", {20'd0, pd_b}, 32'hFFB);
      end
      if (k == 2) check("sp_rst_pd_a", {20'd0, pd_a}, 32'h004);
      if (k == 13) check("sp_cap_pd_b", {20'd0, pd_b}, 32'hFFF);
      if (k == 14) check("sp_busy_done", {31'd0, busy}, 32'd1);
      if (k == 15) check("sp_busy_drop", {31'd0, busy}, 32'd0);
      n_shrst += int'(sh_rst); n_sw1 += int'(sw1); n_sh += int'(sh);
      n_shcmp += int'(sh_cmp); n_sw2 += int'(sw2);
      if (res_valid) begin
        n_rv++; rv_cyc = k; rv_pix = res_pix; rv_bit = res_bit;
        $display("single: result pix=%0d bit=%0d at cycle %0d", res_pix, res_bit, k);
      end
      if (frame_done) fd_cyc = k;
      tick();
    end
    check("sp_sh_rst_len", n_shrst, 4);
    check("sp_sw1_len", n_sw1, 3);
    check("sp_sh_len", n_sh, 2);
    check("sp_sh_cmp_len", n_shcmp, 2);
    check("sp_sw2_len", n_sw2, 2);
    check("sp_rv_count", n_rv, 1);
    check("sp_rv_cycle", rv_cyc, 14);
    check("sp_rv_pix", {26'd0, rv_pix}, 32'd2);
    check("sp_rv_bit", {31'd0, rv_bit}, 32'd1);
    check("sp_fd_cycle", fd_cyc, 14);
`ifdef MIXPIX_RESULT_REG_EN
    check("sp_res_word", {20'd0, res_word}, 32'h004);
`endif

    // ---------------- input stability + cmp_in=0 ----------------
    pix_mask = 12'h004; int_time = 8'd3; cmp_in = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    n_sw1 = 0; n_rv = 0; fd_cyc = 0; rv_bit = 1'b1; rv_pix = '0; dropped = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 3) begin start = 1'b1; int_time = 8'd50; pix_mask = 12'hFFF; end
      if (k == 4) start = 1'b0;
      n_sw1 += int'(sw1);
      if (sh_cmp && !dropped) begin cmp_in = 1'b0; dropped = 1'b1; end
      if (res_valid) begin
        n_rv++; rv_bit = res_bit; rv_pix = res_pix;
        $display("stability: result pix=%0d bit=%0d at cycle %0d", res_pix, res_bit, k);
      end
      if (frame_done) fd_cyc = k;
      tick();
    end
    check("st_sw1_len", n_sw1, 3);
    check("st_fd_cycle", fd_cyc, 14);
    check("st_rv_count", n_rv, 1);
    check("st_rv_pix", {26'd0, rv_pix}, 32'd2);
    check("st_rv_bit0", {31'd0, rv_bit}, 32'd0);
`ifdef MIXPIX_RESULT_REG_EN
    check("st_res_word", {20'd0, res_word}, 32'h000);
`endif

    // ---------------- mask / order ----------------
    cmp_in = 1'b1; pix_mask = 12'h811; int_time = 8'd0; start = 1'b1;
    tick(); start = 1'b0;
    n_rv = 0; fd_cyc = 0;
    for (int i = 0; i < 3; i++) begin ev_pix[i] = -1; ev_cyc[i] = -1; end
    for (int k = 1; k <= 40; k++) begin
      if (res_valid) begin
        if (n_rv < 3) begin ev_pix[n_rv] = int'(res_pix); ev_cyc[n_rv] = k; end
        n_rv++;
        $display("mask: result pix=%0d bit=%0d at cycle %0d", res_pix, res_bit, k);
      end
      if (frame_done) fd_cyc = k;
      if (k == 35) check("mo_busy_drop", {31'd0, busy}, 32'd0);
      tick();
    end
    check("mo_rv_count", n_rv, 3);
    check("mo_pix0", ev_pix[0], 0);
    check("mo_pix1", ev_pix[1], 4);
    check("mo_pix2", ev_pix[2], 11);
    check("mo_cyc0", ev_cyc[0], 12);
    check("mo_cyc1", ev_cyc[1], 23);
    check("mo_cyc2", ev_cyc[2], 34);
    check("mo_fd_cycle", fd_cyc, 34);
    check("mo_invariants", n_viol, 0);
`ifdef MIXPIX_RESULT_REG_EN
    check("mo_res_word", {20'd0, res_word}, 32'h811);
`endif

    // ---------------- empty mask ----------------
    pix_mask = 12'h000; start = 1'b1;
    tick(); start = 1'b0;
    n_fd = 0; n_busy = 0; fd_cyc = 0;
    for (int k = 1; k <= 6; k++) begin
      if (frame_done) begin n_fd++; fd_cyc = k; end
      if (busy) n_busy++;
      tick();
    end
    $display("empty: frame_done count=%0d busy cycles=%0d", n_fd, n_busy);
    check("em_fd_count", n_fd, 1);
    check("em_fd_cycle", fd_cyc, 1);
    check("em_busy", n_busy, 0);

    // ---------------- continuous + abort ----------------
    cont = 1'b1; pix_mask = 12'h001; int_time = 8'd0; start = 1'b1;
    tick(); start = 1'b0;
    n_fd = 0; n_busy = 0; n_rv = 0;
    for (int i = 0; i < 3; i++) fd_list[i] = -1;
    for (int k = 1; k <= 39; k++) begin
      if (frame_done) begin
        if (n_fd < 3) fd_list[n_fd] = k;
        n_fd++;
        $display("cont: frame_done at cycle %0d", k);
      end
      if (res_valid) n_rv++;
      if (!busy) n_busy++;
      if (k == 39) begin
        check("ca_in_integ", {31'd0, sw1}, 32'd1);
        abort = 1'b1;
      end
      tick();
    end
    check("ca_fd_count", n_fd, 3);
    check("ca_fd0", fd_list[0], 12);
    check("ca_fd1", fd_list[1], 23);
    check("ca_fd2", fd_list[2], 34);
    check("ca_rv_count", n_rv, 3);
    check("ca_no_gap", n_busy, 0);
    check("ab_pd_b", {20'd0, pd_b}, 32'hFFF);
    check("ab_outs", {5'd0, pd_a, sw1, sw2, sh_rst, sh, sh_cmp, busy, res_valid,
                      frame_done, 7'd0}, 32'h0);
    abort = 1'b0;
    n_rv = 0; n_fd = 0; n_busy = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (res_valid) n_rv++;
      if (frame_done) n_fd++;
      if (busy) n_busy++;
    end
    $display("abort: after abort rv=%0d fd=%0d busy=%0d", n_rv, n_fd, n_busy);
    check("ab_no_rv", n_rv, 0);
    check("ab_no_fd", n_fd, 0);
    check("ab_idle", n_busy, 0);
    cont = 1'b0;

    // ---------------- reset mid-frame ----------------
    pix_mask = 12'h004; int_time = 8'd3; start = 1'b1;
    tick(); start = 1'b0;
    repeat (5) tick();
    check("mr_in_integ", {31'd0, sw1}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mr_pd_b", {20'd0, pd_b}, 32'hFFF);
    check("mr_outs", {5'd0, pd_a, sw1, sw2, sh_rst, sh, sh_cmp, busy, res_valid,
                      frame_done, res_bit, res_pix}, 32'h0);
    tick(); rst_n = 1'b1;
    repeat (3) tick();
    check("mr_stay_idle", {31'd0, busy}, 32'd0);
    $display("reset mid-frame: outputs returned to reset values");

    check("invariants", n_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mixpix_readout_seq.md
Name: mixpix_readout_seq

Overview:
- Digital sequencer that generates the pixel-array control strobes the MixPix analog readout consumes: per-pixel photodiode select/shunt pairs, sw1, sw2, sh, sh_cmp and sh_rst.
- Scans N_PIX pixels in ascending index order and resynchronises the analog comparator output into one result bit per pixel.
- Sits between the Caravel user-project logic and the analog readout chain (OTA, S/H, comparator).

Parameters:
- N_PIX, 12, number of pixels; must be 2..64.
- INT_W, 8, width of the integration-time counter.
- RST_CYC, 4, cycles in the pixel reset phase; must be ≥1.
- SH_CYC, 2, cycles in the sample phase; must be ≥1.
- CMP_CYC, 2, cycles in the compare phase; must be ≥2 to cover the synchroniser.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle frame start; ignored while busy
- abort  in  1  synchronous frame abort
- cont  in  1  continuous mode: restart the frame automatically
- int_time  in  INT_W  integration cycles; 0 is treated as 1
- pix_mask  in  N_PIX  1 = pixel is scanned
- cmp_in  in  1  asynchronous comparator output
- pd_a  out  N_PIX  pixel connected to the readout bus
- pd_b  out  N_PIX  photodiode shunt (reset switch)
- sw1  out  1  integration switch
- sw2  out  1  compare-path switch
- sh_rst  out  1  S/H reset
- sh  out  1  sample strobe
- sh_cmp  out  1  comparator latch enable
- busy  out  1  frame in progress
- res_valid  out  1  one-cycle result strobe
- res_pix  out  6  pixel index of the result
- res_bit  out  1  comparator result
- frame_done  out  1  one-cycle end-of-frame pulse

Behaviour:
- Reset: pd_b all 1s. All other outputs 0. FSM in IDLE. Synchroniser flops cleared.
- Frame start: start in IDLE latches int_time and pix_mask and raises busy on the next cycle.
  - If the latched mask is zero: frame_done pulses once, busy stays 0, FSM stays in IDLE.
- cmp_in passes through a 2-flop synchroniser to produce cmp_s.
- FSM per selected pixel p:
  - GAP, 1 cycle: pd_b[p]=0, pd_a[p]=0 (break-before-make).
  - RST, RST_CYC cycles: pd_a[p]=1, sh_rst=1.
  - INTEG, max(int_time,1) cycles: pd_a[p]=1, sw1=1.
  - SAMPLE, SH_CYC cycles: pd_a[p]=1, sh=1.
  - CMP, CMP_CYC cycles: pd_a[p]=0, sh_cmp=1, sw2=1.
  - CAP, 1 cycle: pd_b[p]=1; res_bit<=cmp_s, res_pix<=p, res_valid=1 on the following cycle.
- Per-pixel length: 1 + RST_CYC + T + SH_CYC + CMP_CYC + 1 cycles, where T = max(int_time,1).
- After CAP: advance to the next higher-index set bit of the latched mask.
  - If none remains: frame_done pulses in the cycle after CAP.
    - cont=0: FSM goes to IDLE and busy drops.
    - cont=1: relatch inputs and go to GAP of the lowest set pixel with no idle cycle; busy stays 1.
- Invariants:
  - At most one pd_a bit is high at any time.
  - pd_a[i] and pd_b[i] are never both 1.
  - Strobes are glitch-free: all are driven from registers.
- abort, any state: next cycle FSM is in IDLE, pd_b all 1s, all strobes 0. No res_valid and no frame_done.
  - abort has priority over start and over cont.
- start while busy is ignored.
- Changes to int_time or pix_mask mid-frame have no effect until the next frame.
- rst_n asserted mid-frame: immediate return to reset values.

Optional Feature:
- Macro MIXPIX_RESULT_REG_EN.
- Defined:
  - Adds output res_word[N_PIX-1:0].
  - Bit p is updated with the same timing as res_valid.
  - Masked pixels read 0.
  - Cleared at frame start.
  - Held stable from frame_done until the next frame start.
- Undefined:
  - Port and storage are absent.
  - Per-pixel results are available only through res_valid/res_pix/res_bit.

Test Plan:
- Reset: release rst_n with no start -> pd_b=12'hFFF, pd_a=0, all strobes 0, busy=0 for 20 cycles.
- Single pixel: pix_mask=12'h004, int_time=3, cmp_in=1, start -> sh_rst high 4 cycles, sw1 high 3 cycles, sh high 2, sh_cmp high 2; res_valid with res_pix=2, res_bit=1 at cycle 14 after busy rises; frame_done the same cycle; busy low next cycle.
- Mask/order: pix_mask=12'h811, int_time=0 -> results for pixels 0, 4, 11 in that order, 11 cycles apart; pd_a never overlaps and pd_a/pd_b never both high for any pixel.
- Empty mask: pix_mask=0, start -> frame_done 1 cycle, busy never asserted.
- Continuous + abort: cont=1, pix_mask=12'h001 -> frame_done every 11 cycles with no idle gap. abort during INTEG -> next cycle pd_b=12'hFFF and no further res_valid.
- Input stability: toggle start and int_time mid-frame -> frame timing unchanged. Drive cmp_in=0 during CMP and check res_bit=0. With MIXPIX_RESULT_REG_EN, res_word matches per-pixel bits.
